// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-address width and the per-stage enable/clear bundle.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MDU_WAIT = 2'd2,
    ST_MEM_WAIT = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic pc_ena;
    logic ifid_ena;
    logic ifid_clr;
    logic idex_ena;
    logic idex_clr;
    logic exmem_ena;
    logic exmem_clr;
    logic memwb_ena;
  } ctrl_t;

  function automatic ctrl_t ctrl_normal();
    ctrl_t c;
    c           = '0;
    c.pc_ena    = 1'b1;
    c.ifid_ena  = 1'b1;
    c.idex_ena  = 1'b1;
    c.exmem_ena = 1'b1;
    c.memwb_ena = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c           = '0;
    c.ifid_clr  = 1'b1;
    c.idex_clr  = 1'b1;
    c.exmem_clr = 1'b1;
    return c;
  endfunction

  // Front end holds while the long-latency op occupies EX; a bubble drains into MEM.
  function automatic ctrl_t ctrl_mdu_hold();
    ctrl_t c;
    c           = '0;
    c.exmem_clr = 1'b1;
    c.memwb_ena = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c           = '0;
    c.idex_clr  = 1'b1;
    c.exmem_ena = 1'b1;
    c.memwb_ena = 1'b1;
    return c;
  endfunction

  // Squash IF/ID and ID/EX; the PC advances only once fetch data is valid.
  function automatic ctrl_t ctrl_flush(input logic fetch_ok);
    ctrl_t c;
    c           = '0;
    c.pc_ena    = fetch_ok;
    c.ifid_clr  = 1'b1;
    c.idex_clr  = 1'b1;
    c.exmem_ena = 1'b1;
    c.memwb_ena = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_redirect();
    return ctrl_flush(1'b1);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds a
// source operand in decode. x0 never creates a dependency.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_load,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: stall/flush FSM with a return register
// for memory waits and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_load,
  input  logic                   ex_mdu,
  input  logic                   mdu_done,
  input  logic                   ex_redirect,
  input  logic                   mem_req,
  input  logic                   mem_ack,
  input  logic                   if_valid,
  output logic                   pc_ena,
  output logic                   ifid_ena,
  output logic                   ifid_clr,
  output logic                   idex_ena,
  output logic                   idex_clr,
  output logic                   exmem_ena,
  output logic                   exmem_clr,
  output logic                   memwb_ena,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  ctrl_state_e cur_state;
  ctrl_state_e nxt_state;
  ctrl_state_e ret_state;
  ctrl_state_e nxt_ret;
  ctrl_t       ctrl;
  logic        load_use;
  logic        mem_stall;
  logic        stall_inc;

  hazard_detect u_hazard_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_load    (ex_load),
    .load_use   (load_use)
  );

  assign mem_stall = mem_req && !mem_ack;

  // Outputs when leaving MEM_WAIT: the resumed state's own base behaviour,
  // with redirect and load-use still ignored for this cycle.
  function automatic ctrl_t resume_ctrl(input ctrl_state_e st, input logic fetch_ok);
    ctrl_t c;
    case (st)
      ST_FLUSH:    c = ctrl_flush(fetch_ok);
      ST_MDU_WAIT: c = ctrl_mdu_hold();
      default:     c = ctrl_normal();
    endcase
    return c;
  endfunction

  always_comb begin
    ctrl      = ctrl_normal();
    nxt_state = cur_state;
    nxt_ret   = ret_state;
    case (cur_state)
      ST_RUN: begin
        if (mem_stall) begin
          ctrl      = ctrl_freeze();
          nxt_state = ST_MEM_WAIT;
          nxt_ret   = ST_RUN;
        end else if (ex_mdu && !mdu_done) begin
          ctrl      = ctrl_mdu_hold();
          nxt_state = ST_MDU_WAIT;
        end else if (ex_redirect) begin
          ctrl      = ctrl_redirect();
          nxt_state = ST_FLUSH;
        end else if (load_use) begin
          ctrl      = ctrl_load_use();
        end
      end
      ST_FLUSH: begin
        if (mem_stall) begin
          ctrl      = ctrl_freeze();
          nxt_state = ST_MEM_WAIT;
          nxt_ret   = ST_FLUSH;
        end else if (ex_redirect) begin
          ctrl      = ctrl_redirect();
        end else begin
          ctrl      = ctrl_flush(if_valid);
          if (if_valid) begin
            nxt_state = ST_RUN;
          end
        end
      end
      ST_MDU_WAIT: begin
        if (mem_stall) begin
          ctrl      = ctrl_freeze();
          nxt_state = ST_MEM_WAIT;
          nxt_ret   = ST_MDU_WAIT;
        end else if (mdu_done) begin
          ctrl      = ctrl_normal();
          nxt_state = ST_RUN;
        end else begin
          ctrl      = ctrl_mdu_hold();
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          ctrl      = resume_ctrl(ret_state, if_valid);
          nxt_state = ret_state;
        end else begin
          ctrl      = ctrl_freeze();
        end
      end
      default: begin
        ctrl      = ctrl_normal();
        nxt_state = ST_RUN;
      end
    endcase
    if (rst) begin
      ctrl = ctrl_reset();
    end
  end

  assign stall_inc = !ctrl.pc_ena || (cur_state != ST_RUN);

  // State, return register and counter; reset overrides any pending wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_RUN;
      ret_state <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      ret_state <= nxt_ret;
      if (stall_inc && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign pc_ena    = ctrl.pc_ena;
  assign ifid_ena  = ctrl.ifid_ena;
  assign ifid_clr  = ctrl.ifid_clr;
  assign idex_ena  = ctrl.idex_ena;
  assign idex_clr  = ctrl.idex_clr;
  assign exmem_ena = ctrl.exmem_ena;
  assign exmem_clr = ctrl.exmem_clr;
  assign memwb_ena = ctrl.memwb_ena;
  assign state     = cur_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, randomized run against
// a mode-level reference model, then counter saturation and reset-in-wait.
module tb_pipeline_hazard_ctrl;

  // Control vector order: {pc_ena, ifid_ena, ifid_clr, idex_ena, idex_clr, exmem_ena, exmem_clr, memwb_ena}
  localparam logic [7:0] C_RESET  = 8'b0010_1010;
  localparam logic [7:0] C_FREEZE = 8'b0000_0000;
  localparam logic [7:0] C_MDU    = 8'b0000_0011;
  localparam logic [7:0] C_REDIR  = 8'b1010_1101;
  localparam logic [7:0] C_BUBBLE = 8'b0000_1101;
  localparam logic [7:0] C_FLUSHV = 8'b1010_1101;
  localparam logic [7:0] C_FLUSHW = 8'b0010_1101;
  localparam logic [7:0] C_NORMAL = 8'b1101_0101;

  localparam int M_RUN = 0;
  localparam int M_FLUSH = 1;
  localparam int M_MDU = 2;
  localparam int M_MEM = 3;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_load;
    logic       ex_mdu;
    logic       mdu_done;
    logic       ex_redirect;
    logic       mem_req;
    logic       mem_ack;
    logic       if_valid;
  } stim_t;

  typedef struct {
    string       name;
    stim_t       s;
    logic [7:0]  ctl;
    logic [1:0]  st;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_load, ex_mdu, mdu_done;
  logic        ex_redirect, mem_req, mem_ack, if_valid;
  logic        pc_ena, ifid_ena, ifid_clr, idex_ena, idex_clr;
  logic        exmem_ena, exmem_clr, memwb_ena;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  int m_mode  = M_RUN;
  int m_saved = M_RUN;
  int m_cnt   = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_load     (ex_load),
    .ex_mdu      (ex_mdu),
    .mdu_done    (mdu_done),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .if_valid    (if_valid),
    .pc_ena      (pc_ena),
    .ifid_ena    (ifid_ena),
    .ifid_clr    (ifid_clr),
    .idex_ena    (idex_ena),
    .idex_clr    (idex_clr),
    .exmem_ena   (exmem_ena),
    .exmem_clr   (exmem_clr),
    .memwb_ena   (memwb_ena),
    .state       (state),
    .stall_cnt   (stall_cnt)
  );

  function automatic stim_t idle();
    stim_t s;
    s          = '0;
    s.if_valid = 1'b1;
    return s;
  endfunction

  // Reference model: pick what the pipeline should do this cycle from the mode
  // and the inputs, then map that to the control pattern.
  function automatic void modelPredict(input stim_t s, output logic [7:0] ctl,
                                       output int nmode, output int nsaved, output int ncnt);
    bit hazard;
    bit blocked;
    nmode  = m_mode;
    nsaved = m_saved;
    ncnt   = m_cnt;
    if (s.rst) begin
      ctl    = C_RESET;
      nmode  = M_RUN;
      nsaved = M_RUN;
      ncnt   = 0;
      return;
    end
    blocked = s.mem_req && !s.mem_ack;
    hazard  = s.ex_load && (s.ex_rd != 0) &&
              ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) || (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
    if (m_mode == M_MEM) begin
      if (s.mem_ack) begin
        nmode = m_saved;
        if (m_saved == M_FLUSH)    ctl = s.if_valid ? C_FLUSHV : C_FLUSHW;
        else if (m_saved == M_MDU) ctl = C_MDU;
        else                       ctl = C_NORMAL;
      end else begin
        ctl = C_FREEZE;
      end
    end else if (blocked) begin
      ctl    = C_FREEZE;
      nsaved = m_mode;
      nmode  = M_MEM;
    end else if (m_mode == M_MDU) begin
      ctl = s.mdu_done ? C_NORMAL : C_MDU;
      if (s.mdu_done) nmode = M_RUN;
    end else if (m_mode == M_FLUSH) begin
      if (s.ex_redirect)    ctl = C_REDIR;
      else if (s.if_valid) begin
        ctl   = C_FLUSHV;
        nmode = M_RUN;
      end else              ctl = C_FLUSHW;
    end else begin
      if (s.ex_mdu && !s.mdu_done) begin
        ctl   = C_MDU;
        nmode = M_MDU;
      end else if (s.ex_redirect) begin
        ctl   = C_REDIR;
        nmode = M_FLUSH;
      end else if (hazard) ctl = C_BUBBLE;
      else                 ctl = C_NORMAL;
    end
    if (!ctl[7] || m_mode != M_RUN) ncnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
  endfunction

  task automatic applyStimulus(input stim_t s);
    rst         = s.rst;
    id_rs1      = s.id_rs1;
    id_rs2      = s.id_rs2;
    id_use_rs1  = s.id_use_rs1;
    id_use_rs2  = s.id_use_rs2;
    ex_rd       = s.ex_rd;
    ex_load     = s.ex_load;
    ex_mdu      = s.ex_mdu;
    mdu_done    = s.mdu_done;
    ex_redirect = s.ex_redirect;
    mem_req     = s.mem_req;
    mem_ack     = s.mem_ack;
    if_valid    = s.if_valid;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ectl,
                             input logic [1:0] est, input logic [15:0] ecnt);
    logic [7:0] got;
    got = {pc_ena, ifid_ena, ifid_clr, idex_ena, idex_clr, exmem_ena, exmem_clr, memwb_ena};
    checks++;
    if (got !== ectl || state !== est || stall_cnt !== ecnt) begin
      failures++;
      $display("[TB] FAIL %s: got ctl=%b state=%0d cnt=%0h, expected ctl=%b state=%0d cnt=%0h",
               name, got, state, stall_cnt, ectl, est, ecnt);
    end
  endtask

  // mode 0: drive only, 1: compare to given constants, 2: compare to model
  task automatic runCycle(input stim_t s, input int mode, input string name,
                          input logic [7:0] ectl, input logic [1:0] est, input logic [15:0] ecnt);
    logic [7:0] p_ctl;
    int nm, ns, nc;
    applyStimulus(s);
    @(negedge clk);
    modelPredict(s, p_ctl, nm, ns, nc);
    if (mode == 1)      checkOutput(name, ectl, est, ecnt);
    else if (mode == 2) checkOutput(name, p_ctl, 2'(m_mode), 16'(m_cnt));
    @(posedge clk);
    m_mode  = nm;
    m_saved = ns;
    m_cnt   = nc;
    #1;
  endtask

  task automatic addVec(input string n, input stim_t s, input logic [7:0] c,
                        input logic [1:0] st, input logic [15:0] cnt);
    vec_t v;
    v.name = n;
    v.s    = s;
    v.ctl  = c;
    v.st   = st;
    v.cnt  = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    stim_t s;

    s = idle(); s.rst = 1'b1;
    addVec("reset", s, C_RESET, 2'd0, 16'd0);
    s = idle();
    addVec("normal", s, C_NORMAL, 2'd0, 16'd0);
    s = idle(); s.ex_load = 1; s.ex_rd = 5; s.id_rs1 = 5; s.id_use_rs1 = 1;
    addVec("loaduse_rs1", s, C_BUBBLE, 2'd0, 16'd0);
    s = idle();
    addVec("after_loaduse", s, C_NORMAL, 2'd0, 16'd1);
    s = idle(); s.ex_load = 1; s.ex_rd = 0; s.id_rs1 = 0; s.id_use_rs1 = 1;
    addVec("x0_no_hazard", s, C_NORMAL, 2'd0, 16'd1);
    s = idle(); s.ex_load = 1; s.ex_rd = 7; s.id_rs2 = 7; s.id_use_rs2 = 1;
    addVec("loaduse_rs2", s, C_BUBBLE, 2'd0, 16'd1);
    s = idle(); s.ex_load = 1; s.ex_rd = 7; s.id_rs2 = 7; s.id_use_rs2 = 0;
    addVec("rs2_unused", s, C_NORMAL, 2'd0, 16'd2);
    s = idle(); s.ex_redirect = 1; s.if_valid = 0; s.ex_load = 1; s.ex_rd = 5; s.id_rs1 = 5; s.id_use_rs1 = 1;
    addVec("redirect", s, C_REDIR, 2'd0, 16'd2);
    s = idle(); s.if_valid = 0;
    addVec("flush_wait", s, C_FLUSHW, 2'd1, 16'd2);
    s = idle();
    addVec("flush_valid", s, C_FLUSHV, 2'd1, 16'd3);
    s = idle();
    addVec("flush_done", s, C_NORMAL, 2'd0, 16'd4);
    s = idle(); s.ex_mdu = 1;
    addVec("mdu_entry", s, C_MDU, 2'd0, 16'd4);
    addVec("mdu_wait1", s, C_MDU, 2'd2, 16'd5);
    addVec("mdu_wait2", s, C_MDU, 2'd2, 16'd6);
    addVec("mdu_wait3", s, C_MDU, 2'd2, 16'd7);
    s = idle(); s.ex_mdu = 1; s.mdu_done = 1; s.ex_redirect = 1;
    addVec("mdu_done", s, C_NORMAL, 2'd2, 16'd8);
    s = idle(); s.ex_mdu = 1; s.mdu_done = 1;
    addVec("mdu_zero_stall", s, C_NORMAL, 2'd0, 16'd9);
    s = idle();
    addVec("after_mdu", s, C_NORMAL, 2'd0, 16'd9);
    s = idle(); s.ex_mdu = 1;
    addVec("mdu_entry2", s, C_MDU, 2'd0, 16'd9);
    s = idle(); s.ex_mdu = 1; s.mem_req = 1;
    addVec("mem_in_mdu", s, C_FREEZE, 2'd2, 16'd10);
    addVec("mem_wait1", s, C_FREEZE, 2'd3, 16'd11);
    addVec("mem_wait2", s, C_FREEZE, 2'd3, 16'd12);
    s = idle(); s.ex_mdu = 1; s.mem_req = 1; s.mem_ack = 1;
    addVec("mem_ack_to_mdu", s, C_MDU, 2'd3, 16'd13);
    s = idle(); s.ex_mdu = 1; s.mdu_done = 1;
    addVec("mdu_done2", s, C_NORMAL, 2'd2, 16'd14);
    s = idle();
    addVec("run_again", s, C_NORMAL, 2'd0, 16'd15);
    s = idle(); s.mem_req = 1; s.mem_ack = 1;
    addVec("mem_fast_ack", s, C_NORMAL, 2'd0, 16'd15);
    s = idle(); s.ex_redirect = 1; s.if_valid = 0;
    addVec("redirect2", s, C_REDIR, 2'd0, 16'd15);
    s = idle(); s.mem_req = 1; s.if_valid = 0;
    addVec("mem_in_flush", s, C_FREEZE, 2'd1, 16'd15);
    s = idle(); s.mem_req = 1; s.mem_ack = 1; s.if_valid = 0;
    addVec("mem_ack_to_flush", s, C_FLUSHW, 2'd3, 16'd16);
    s = idle();
    addVec("flush_valid2", s, C_FLUSHV, 2'd1, 16'd17);
    s = idle();
    addVec("run3", s, C_NORMAL, 2'd0, 16'd18);
    s = idle(); s.ex_redirect = 1; s.if_valid = 0;
    addVec("redirect3", s, C_REDIR, 2'd0, 16'd18);
    s = idle(); s.ex_redirect = 1;
    addVec("redirect_restart", s, C_REDIR, 2'd1, 16'd18);
    s = idle();
    addVec("flush_valid3", s, C_FLUSHV, 2'd1, 16'd19);
    s = idle();
    addVec("run4", s, C_NORMAL, 2'd0, 16'd20);
    s = idle(); s.mem_req = 1; s.ex_mdu = 1; s.ex_redirect = 1;
    addVec("mem_priority", s, C_FREEZE, 2'd0, 16'd20);
    s = idle(); s.mem_req = 1; s.mem_ack = 1; s.ex_redirect = 1; s.ex_load = 1; s.ex_rd = 3; s.id_rs1 = 3; s.id_use_rs1 = 1;
    addVec("mem_ack_to_run", s, C_NORMAL, 2'd3, 16'd21);
    s = idle();
    addVec("run5", s, C_NORMAL, 2'd0, 16'd22);
    s = idle(); s.mem_req = 1;
    addVec("mem_entry", s, C_FREEZE, 2'd0, 16'd22);
    s = idle(); s.mem_req = 1; s.rst = 1;
    addVec("reset_in_mem", s, C_RESET, 2'd3, 16'd23);
    s = idle();
    addVec("after_reset", s, C_NORMAL, 2'd0, 16'd0);

    s = idle(); s.rst = 1;
    applyStimulus(s);
    @(posedge clk);
    #1;
    runCycle(s, 0, "init", '0, '0, '0);
    runCycle(s, 0, "init", '0, '0, '0);

    foreach (vecs[i]) runCycle(vecs[i].s, 1, vecs[i].name, vecs[i].ctl, vecs[i].st, vecs[i].cnt);

    for (int i = 0; i < 3000; i++) begin
      s             = '0;
      s.rst         = ($urandom_range(0, 99) == 0);
      s.id_rs1      = 5'($urandom_range(0, 3));
      s.id_rs2      = 5'($urandom_range(0, 3));
      s.id_use_rs1  = 1'($urandom);
      s.id_use_rs2  = 1'($urandom);
      s.ex_rd       = 5'($urandom_range(0, 3));
      s.ex_load     = 1'($urandom);
      s.ex_mdu      = ($urandom_range(0, 4) == 0);
      s.mdu_done    = ($urandom_range(0, 2) == 0);
      s.ex_redirect = ($urandom_range(0, 5) == 0);
      s.mem_req     = ($urandom_range(0, 3) == 0);
      s.mem_ack     = 1'($urandom);
      s.if_valid    = 1'($urandom);
      runCycle(s, 2, "random", '0, '0, '0);
    end

    s = idle(); s.rst = 1;
    runCycle(s, 0, "sat_reset", '0, '0, '0);
    s = idle(); s.ex_mdu = 1;
    for (int i = 0; i < 70000; i++) runCycle(s, 0, "sat_fill", '0, '0, '0);
    runCycle(s, 1, "saturated", C_MDU, 2'd2, 16'hFFFF);
    runCycle(s, 1, "no_wrap", C_MDU, 2'd2, 16'hFFFF);
    s = idle(); s.ex_mdu = 1; s.mem_req = 1;
    runCycle(s, 1, "sat_mem_entry", C_FREEZE, 2'd2, 16'hFFFF);
    s.rst = 1;
    runCycle(s, 1, "sat_reset_in_mem", C_RESET, 2'd3, 16'hFFFF);
    s = idle();
    runCycle(s, 1, "sat_after_reset", C_NORMAL, 2'd0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
